// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester sequencer for the single memory port.
// Requester A (fetch) and B (load/store) share the port through an external
// 2:1 mux driven by S. A winner keeps the port for LAT cycles, then read data
// is registered and a one-cycle DONE is returned to that requester.
// Optional build macro: ARB_FIXED_PRIO_EN -- A always wins contention
// (B may starve); otherwise contention is resolved round-robin via LAST.
module mem_port_arbiter #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2   // legal 1..15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_A,
  input  logic [WIDTH-1:0] ADDR_A,
  input  logic [WIDTH-1:0] WDATA_A,
  input  logic             WE_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] ADDR_B,
  input  logic [WIDTH-1:0] WDATA_B,
  input  logic             WE_B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             DONE_A,
  output logic             DONE_B,
  output logic [WIDTH-1:0] RDATA,
  output logic             S,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  output logic             MEM_WE,
  output logic             MEM_EN,
  input  logic [WIDTH-1:0] MEM_RDATA
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
  } req_t;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic             last_q, last_d;     // 1 = B was served last
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             win_b;
  req_t             req_a, req_b, req_sel;

  assign req_a = '{addr: ADDR_A, wdata: WDATA_A, we: WE_A};
  assign req_b = '{addr: ADDR_B, wdata: WDATA_B, we: WE_B};

  // Arbitration winner when at least one request is present (1 = B).
`ifdef ARB_FIXED_PRIO_EN
  assign win_b = REQ_B & ~REQ_A;
`else
  assign win_b = REQ_B & (~REQ_A | ~last_q);
`endif

  // State register; reset aborts any access in flight without a DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: grant in IDLE, count out LAT cycles in ACCESS, then complete.
  // The completion edge returns to IDLE, so the DONE cycle never carries a
  // grant; that cycle is the requester's window to drop REQ, giving a
  // request-to-request period of LAT+1.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          state_d = ACCESS;
          s_d     = win_b;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d  = MEM_RDATA;   // captured on writes too
          done_a_d = ~s_q;
          done_b_d = s_q;
          last_d   = s_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port side: S holds through IDLE so the mux never glitches; WE is gated.
  assign req_sel   = s_q ? req_b : req_a;
  assign MEM_EN    = (state_q == ACCESS);
  assign MEM_ADDR  = req_sel.addr;
  assign MEM_WDATA = req_sel.wdata;
  assign MEM_WE    = MEM_EN & req_sel.we;
  assign S         = s_q;
  assign GNT_A     = MEM_EN & ~s_q;
  assign GNT_B     = MEM_EN & s_q;
  assign DONE_A    = done_a_q;
  assign DONE_B    = done_b_q;
  assign RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps then random traffic, checked
// against a transaction-level model (owner + cycles remaining).
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int LAT = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [W-1:0] addr_a = 0, wdata_a = 0, addr_b = 0, wdata_b = 0, mem_rdata = 0;
  logic gnt_a, gnt_b, done_a, done_b, s, mem_we, mem_en;
  logic [W-1:0] rdata, mem_addr, mem_wdata;
  logic g1_gnt_a, g1_gnt_b, g1_done_a, g1_done_b, g1_s, g1_we, g1_en;
  logic [W-1:0] g1_rdata, g1_addr, g1_wdata;

  int total = 0, bad = 0;

  // model: owner 0=none 1=A 2=B; left = grant cycles still to run
  int m_owner, m_left, m_done;
  bit m_last_b, m_sel;
  logic [W-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_A(req_a), .ADDR_A(addr_a), .WDATA_A(wdata_a), .WE_A(we_a),
    .REQ_B(req_b), .ADDR_B(addr_b), .WDATA_B(wdata_b), .WE_B(we_b),
    .GNT_A(gnt_a), .GNT_B(gnt_b), .DONE_A(done_a), .DONE_B(done_b),
    .RDATA(rdata), .S(s), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_WE(mem_we), .MEM_EN(mem_en), .MEM_RDATA(mem_rdata));

  mem_port_arbiter #(.WIDTH(W), .LAT(1)) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_A(req_a), .ADDR_A(addr_a), .WDATA_A(wdata_a), .WE_A(we_a),
    .REQ_B(req_b), .ADDR_B(addr_b), .WDATA_B(wdata_b), .WE_B(we_b),
    .GNT_A(g1_gnt_a), .GNT_B(g1_gnt_b), .DONE_A(g1_done_a), .DONE_B(g1_done_b),
    .RDATA(g1_rdata), .S(g1_s), .MEM_ADDR(g1_addr), .MEM_WDATA(g1_wdata),
    .MEM_WE(g1_we), .MEM_EN(g1_en), .MEM_RDATA(mem_rdata));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_done = 0;
    m_last_b = 1'b1; m_sel = 1'b0; m_rdata = '0;
  endtask

  // One rising edge of the reference: finish or start a transaction.
  task automatic model_step();
    int nd, w;
    nd = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_rdata = mem_rdata;
        nd = m_owner;
        m_last_b = (m_owner == 2);
        m_owner = 0;
      end
    end else if (req_a || req_b) begin
`ifdef ARB_FIXED_PRIO_EN
      w = req_a ? 1 : 2;
`else
      if (req_a && req_b) w = m_last_b ? 1 : 2;
      else                w = req_a ? 1 : 2;
`endif
      m_owner = w;
      m_left = LAT;
      m_sel = (w == 2);
    end
    m_done = nd;
  endtask

  task automatic check_all(input string tag);
    logic en, we;
    en = (m_owner != 0);
    we = en && (m_sel ? we_b : we_a);
    chk({tag, "_gnt_a"}, 16'(gnt_a), 16'(m_owner == 1));
    chk({tag, "_gnt_b"}, 16'(gnt_b), 16'(m_owner == 2));
    chk({tag, "_done_a"}, 16'(done_a), 16'(m_done == 1));
    chk({tag, "_done_b"}, 16'(done_b), 16'(m_done == 2));
    chk({tag, "_rdata"}, rdata, m_rdata);
    chk({tag, "_s"}, 16'(s), 16'(m_sel));
    chk({tag, "_en"}, 16'(mem_en), 16'(en));
    chk({tag, "_we"}, 16'(mem_we), 16'(we));
    chk({tag, "_addr"}, mem_addr, m_sel ? addr_b : addr_a);
    chk({tag, "_wdata"}, mem_wdata, m_sel ? wdata_b : wdata_a);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    int seq[$];
    int dcyc[$];
    bit pa, pb;

    // reset state
    model_reset();
    #1 check_all("reset");
    tick("reset_hold");
    rst_n = 1'b1;

    // A read, LAT=2
    req_a = 1; addr_a = 16'h0005; we_a = 0; mem_rdata = 16'h1234;
    tick("a_rd0");
    chk("a_rd_gnt0", 16'(gnt_a), 16'd1);
    chk("a_rd_addr", mem_addr, 16'h0005);
    tick("a_rd1");
    chk("a_rd_gnt1", 16'(gnt_a), 16'd1);
    tick("a_rd2");
    chk("a_rd_done", 16'(done_a), 16'd1);
    chk("a_rd_rdata", rdata, 16'h1234);
    chk("a_rd_gnt_off", 16'(gnt_a), 16'd0);
    req_a = 0;
    tick("a_rd3");

    // B write
    req_b = 1; addr_b = 16'h000A; wdata_b = 16'h00FF; we_b = 1;
    tick("b_wr0");
    chk("b_wr_s", 16'(s), 16'd1);
    chk("b_wr_we", 16'(mem_we), 16'd1);
    chk("b_wr_wdata", mem_wdata, 16'h00FF);
    tick("b_wr1");
    chk("b_wr_en1", 16'(mem_en), 16'd1);
    tick("b_wr2");
    chk("b_wr_done", 16'(done_b), 16'd1);
    req_b = 0; we_b = 0;
    tick("b_wr3");

    // contention held: A,B,A,B (fixed prio: A,A,A,A)
    req_a = 1; req_b = 1; pa = 0; pb = 0;
    for (int i = 0; i < 12; i++) begin
      tick("both");
      if (gnt_a && !pa) seq.push_back(1);
      if (gnt_b && !pb) seq.push_back(2);
      pa = gnt_a; pb = gnt_b;
    end
    chk("both_ngrants", 16'(seq.size()), 16'd4);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk("both_order", 16'(seq[i]), 16'd1);
`else
      chk("both_order", 16'(seq[i]), (i % 2 == 0) ? 16'd1 : 16'd2);
`endif
    end
    req_a = 0; req_b = 0;
    tick("both_end");

    // A held alone: DONE_A every LAT+1 cycles
    req_a = 1;
    for (int i = 0; i < 12; i++) begin
      tick("a_stream");
      if (done_a) dcyc.push_back(i);
    end
    chk("stream_ndone", 16'(dcyc.size()), 16'd4);
    for (int i = 1; i < dcyc.size(); i++)
      chk("stream_period", 16'(dcyc[i] - dcyc[i-1]), 16'(LAT + 1));
    req_a = 0;
    tick("a_stream_end");

    // reset mid-access of B
    req_b = 1;
    tick("b_abort0");
    chk("b_abort_gnt", 16'(gnt_b), 16'd1);
    #4 rst_n = 0;
    model_reset();
    #1;
    chk("b_abort_en", 16'(mem_en), 16'd0);
    chk("b_abort_gntb", 16'(gnt_b), 16'd0);
    chk("b_abort_s", 16'(s), 16'd0);
    check_all("b_abort_rst");
    req_b = 0;
    tick("b_abort_hold");
    chk("b_abort_nodone", 16'(done_b), 16'd0);
    rst_n = 1;
    req_a = 1; req_b = 1;
    tick("post_rst_cont");
    chk("post_rst_win_a", 16'(gnt_a), 16'd1);
    req_a = 0; req_b = 0;
    for (int i = 0; i < 3; i++) tick("post_rst_drain");

    // LAT=1 instance, single A request
    rst_n = 0;
    model_reset();
    tick("l1_rst");
    rst_n = 1;
    req_a = 1; addr_a = 16'h0003; we_a = 0; mem_rdata = 16'hBEEF;
    tick("l1_e0");
    chk("l1_gnt", 16'(g1_gnt_a), 16'd1);
    chk("l1_nodone", 16'(g1_done_a), 16'd0);
    tick("l1_e1");
    chk("l1_gnt_off", 16'(g1_gnt_a), 16'd0);
    chk("l1_done", 16'(g1_done_a), 16'd1);
    chk("l1_rdata", g1_rdata, 16'hBEEF);
    req_a = 0;
    tick("l1_e2");

    // random traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      tick("rnd");
      if (!rst_n) rst_n = 1;
      req_a = ($urandom_range(0, 9) < 6);
      req_b = ($urandom_range(0, 9) < 6);
      we_a = $urandom_range(0, 1) == 1;
      we_b = $urandom_range(0, 1) == 1;
      addr_a = 16'($urandom); addr_b = 16'($urandom);
      wdata_a = 16'($urandom); wdata_b = 16'($urandom);
      mem_rdata = 16'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 0;
        model_reset();
        #1 check_all("rnd_rst");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
